seg7_scan_mux: RTL and testbench
================================

// Module: seg7_scan_mux
// PURPOSE
//  Time-multiplexed driver for the 3-digit 7-segment display of the counter design.
//  Consumes three BCD digits from the counter stage and drives the shared segment bus
//  (d7sp) and the digit-select transistors (transistor) that leave via uo_out/uio_out.
//  Frame-synchronous digit latching (no tearing), blank gap between digits (no ghosting),
//  optional leading-zero blanking.
// PARAMETERS
//  ON_TICKS        10000  clk cycles a digit is lit per slot; must be >= 1
//  BLANK_TICKS     100    clk cycles all-off before each digit; 0 = gap skipped
//  CNT_W           16     slot-counter width; must hold max(ON_TICKS, BLANK_TICKS)
//  SEG_ACTIVE_LOW  0      1 = invert d7sp at the output flops
//  SEL_ACTIVE_LOW  0      1 = invert transistor at the output flops
// PORTS
//  clk            in   1   system clock
//  rst_n          in   1   asynchronous active-low reset
//  en_i           in   1   scan enable; 0 = display dark
//  digits_i       in   12  {d2,d1,d0} BCD, d0 = least significant
//  digits_valid_i in   1   1-cycle strobe: new digits_i to show
//  lz_blank_i     in   1   1 = blank leading zeros (d2, then d1)
//  transistor     out  3   one-hot digit select, bit k = digit k
//  d7sp           out  7   segments {g,f,e,d,c,b,a}
//  frame_o        out  1   1-cycle pulse at end of each full 3-digit scan
// BEHAVIOUR
//  Reset (async): state IDLE, idx=0, cnt=0, shadow=0, pending=0, pend_flag=0,
//   transistor/d7sp at inactive level (all 0 before polarity inversion), frame_o=0.
//  Outputs are flops; they take the new value on the same edge the FSM enters a state.
//  FSM: IDLE -> BLANK (or ON if BLANK_TICKS=0) when en_i=1; idx=0.
//   BLANK: transistor off, d7sp off, BLANK_TICKS cycles -> ON.
//   ON: transistor[idx]=1, d7sp=decode(shadow digit idx), ON_TICKS cycles; then
//   idx<2: idx++ -> BLANK; idx==2: idx=0, frame_o=1 for 1 cycle -> BLANK.
//  Frame period = 3*(ON_TICKS+BLANK_TICKS) cycles.
//  Digit latching: digits_valid_i writes pending and sets pend_flag. On leaving IDLE
//   and at every frame end, shadow<=pending if pend_flag, and pend_flag clears. If the
//   strobe coincides with that edge, shadow takes digits_i directly (bypass).
//   The strobe mid-frame never alters the current frame.
//  Decode: 0-9 standard (0=0111111, 1=0000110, 2=1011011, 3=1001111, ... 8=1111111);
//   10-15 show dash 1000000.
//  Leading-zero blank (lz_blank_i, sampled each slot): d2==0 -> d2 segments off;
//   d2==0 && d1==0 -> d1 segments off; d0 never blanked. Select still asserted.
//  en_i falls mid-slot: next edge -> IDLE, outputs off, idx=0, cnt=0; pending kept.
//  rst_n low at any time: outputs inactive immediately, no clock required.
//  Width: cnt compares to ON_TICKS-1 / BLANK_TICKS-1 in CNT_W bits; no wrap inside slot.
// STRUCTURE
//  Shared package seg7_pkg: FSM state encoding (IDLE/BLANK/ON), SEG_OFF/SEG_DASH
//   constants, 7-bit segment patterns for 0-9.
//  Sub-module seg7_decode (combinational nibble -> 7 segments), instanced once on
//   the shadow digit selected by idx.
//  Top body: slot counter, idx counter, FSM, shadow/pending regs, output flops.
// TESTING (ON_TICKS=4, BLANK_TICKS=1, polarity params 0)
//  1 rst_n=0 mid-ON, no clk -> transistor=000, d7sp=0000000, frame_o=0 immediately.
//  2 digits_i=12'h123 strobe, en_i=1, lz=0 -> 1 blank, 001/1001111 x4, blank,
//    010/1011011 x4, blank, 100/0000110 x4; frame_o pulses every 15 cycles.
//  3 digits_i=12'h007, lz=1 -> slots 2,1 select asserted with d7sp=0; slot 0 = 0000111;
//    lz=0 -> slots 2,1 show 0111111.
//  4 strobe 12'h456 during slot 1 -> rest of frame shows 1,2,3 digits; next frame 6,5,4.
//    Strobe on frame-end edge -> very next frame shows new digits.
//  5 en_i=0 in ON of slot 1 -> outputs off next edge; en_i=1 restarts blank, then slot 0.
//  6 digits_i=12'hA0F -> slot 2 and slot 0 show 1000000, slot 1 shows 0111111.

Source files
------------

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared types and segment constants for the 7-segment scan driver
//
// Purpose: FSM state encoding, blank/dash patterns and the 0-9 segment table.
// Segment bit order is {g,f,e,d,c,b,a}.
package seg7_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_ON    = 2'd2
    } state_t;

    localparam logic [6:0] SEG_OFF  = 7'b0000000;
    localparam logic [6:0] SEG_DASH = 7'b1000000;

    // Index k holds the pattern for decimal digit k.
    localparam logic [9:0][6:0] SEG_DIGITS = {
        7'b1101111,     // 9
        7'b1111111,     // 8
        7'b0000111,     // 7
        7'b1111101,     // 6
        7'b1101101,     // 5
        7'b1100110,     // 4
        7'b1001111,     // 3
        7'b1011011,     // 2
        7'b0000110,     // 1
        7'b0111111      // 0
    };

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - combinational BCD nibble to 7-segment decoder
//
// Purpose: 0-9 map to the standard patterns, 10-15 show a dash.
// Ports:
//   i_digit  in  4  nibble to display
//   o_seg    out 7  segments {g,f,e,d,c,b,a}, active high
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_DASH;
        if (i_digit <= 4'd9) begin
            o_seg = SEG_DIGITS[i_digit];
        end
    end

endmodule

// File: rtl/seg7_scan_mux.sv
// rtl/seg7_scan_mux.sv - time-multiplexed 3-digit 7-segment display driver
//
// Purpose: scans three BCD digits onto a shared segment bus with a blank gap
// before each digit, frame-synchronous digit latching and leading-zero blanking.
// Ports:
//   clk             in   1   system clock
//   rst_n           in   1   asynchronous active-low reset
//   en_i            in   1   scan enable; 0 = display dark
//   digits_i        in   12  {d2,d1,d0} BCD, d0 least significant
//   digits_valid_i  in   1   1-cycle strobe: new digits_i to show
//   lz_blank_i      in   1   1 = blank leading zeros
//   transistor      out  3   one-hot digit select, bit k = digit k
//   d7sp            out  7   segments {g,f,e,d,c,b,a}
//   frame_o         out  1   1-cycle pulse at end of each 3-digit scan
module seg7_scan_mux
    import seg7_pkg::*;
#(
    parameter int ON_TICKS       = 10000,
    parameter int BLANK_TICKS    = 100,
    parameter int CNT_W          = 16,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit SEL_ACTIVE_LOW = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en_i,
    input  logic [11:0] digits_i,
    input  logic        digits_valid_i,
    input  logic        lz_blank_i,
    output logic [2:0]  transistor,
    output logic [6:0]  d7sp,
    output logic        frame_o
);

    localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(ON_TICKS - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_TICKS > 0) ? BLANK_TICKS - 1 : 0);
    localparam bit               HAS_GAP    = (BLANK_TICKS > 0);
    // The output flops hold the physical pin level; "off" is the mask itself.
    localparam logic [2:0]       SEL_MASK   = {3{SEL_ACTIVE_LOW}};
    localparam logic [6:0]       SEG_MASK   = {7{SEG_ACTIVE_LOW}};

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [1:0]        r_idx;
    logic [1:0]        w_idx_nxt;
    logic [11:0]       r_shadow;
    logic [11:0]       r_pending;
    logic              r_pend_flag;
    logic [11:0]       w_shadow_nxt;
    logic              w_latch;
    logic              w_frame_end;
    logic              w_on_start;
    logic [3:0]        w_digit;
    logic [6:0]        w_seg_dec;
    logic [6:0]        w_seg;
    logic [2:0]        w_sel;
    logic              w_lz_blank;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_latch     = 1'b0;
        w_frame_end = 1'b0;
        w_on_start  = 1'b0;
        if (!en_i) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
            w_idx_nxt   = 2'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_latch   = 1'b1;
                    w_cnt_nxt = '0;
                    w_idx_nxt = 2'd0;
                    if (HAS_GAP) begin
                        w_state_nxt = ST_BLANK;
                    end else begin
                        w_state_nxt = ST_ON;
                        w_on_start  = 1'b1;
                    end
                end
                ST_BLANK: begin
                    if (r_cnt == BLANK_LAST) begin
                        w_state_nxt = ST_ON;
                        w_cnt_nxt   = '0;
                        w_on_start  = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                ST_ON: begin
                    if (r_cnt == ON_LAST) begin
                        w_cnt_nxt = '0;
                        if (r_idx == 2'd2) begin
                            w_idx_nxt   = 2'd0;
                            w_frame_end = 1'b1;
                            w_latch     = 1'b1;
                        end else begin
                            w_idx_nxt = r_idx + 2'd1;
                        end
                        if (HAS_GAP) begin
                            w_state_nxt = ST_BLANK;
                        end else begin
                            w_state_nxt = ST_ON;
                            w_on_start  = 1'b1;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = 2'd0;
                end
            endcase
        end
    end

    // A strobe landing on the latch edge wins over the pending copy, so the
    // very next frame shows it.
    always_comb begin
        w_shadow_nxt = r_shadow;
        if (w_latch) begin
            if (digits_valid_i) begin
                w_shadow_nxt = digits_i;
            end else if (r_pend_flag) begin
                w_shadow_nxt = r_pending;
            end
        end
    end

    // Decode from next-cycle shadow/idx so the lit slot already shows what
    // the FSM is entering, including the zero-gap ON->ON case.
    always_comb begin
        case (w_idx_nxt)
            2'd0:    w_digit = w_shadow_nxt[3:0];
            2'd1:    w_digit = w_shadow_nxt[7:4];
            default: w_digit = w_shadow_nxt[11:8];
        endcase
        w_lz_blank = lz_blank_i &&
                     (((w_idx_nxt == 2'd2) && (w_shadow_nxt[11:8] == 4'd0)) ||
                      ((w_idx_nxt == 2'd1) && (w_shadow_nxt[11:4] == 8'd0)));
        w_seg = w_lz_blank ? SEG_OFF : w_seg_dec;
        w_sel = 3'b001 << w_idx_nxt;
    end

    seg7_decode u_decode (
        .i_digit (w_digit),
        .o_seg   (w_seg_dec)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_idx       <= 2'd0;
            r_shadow    <= 12'd0;
            r_pending   <= 12'd0;
            r_pend_flag <= 1'b0;
            transistor  <= SEL_MASK;
            d7sp        <= SEG_MASK;
            frame_o     <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_idx    <= w_idx_nxt;
            r_shadow <= w_shadow_nxt;
            if (digits_valid_i) begin
                r_pending <= digits_i;
            end
            if (w_latch) begin
                r_pend_flag <= 1'b0;
            end else if (digits_valid_i) begin
                r_pend_flag <= 1'b1;
            end
            frame_o <= w_frame_end;
            if (w_state_nxt != ST_ON) begin
                transistor <= SEL_MASK;
                d7sp       <= SEG_MASK;
            end else if (w_on_start) begin
                transistor <= w_sel ^ SEL_MASK;
                d7sp       <= w_seg ^ SEG_MASK;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// tb/tb_seg7_scan_mux.sv - randomized scoreboard bench for seg7_scan_mux
module tb_seg7_scan_mux;

    localparam int ON_T    = 4;
    localparam int BLANK_T = 1;
    localparam int FRAME_T = 3 * (ON_T + BLANK_T);

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en_i;
    logic [11:0] digits_i;
    logic        digits_valid_i;
    logic        lz_blank_i;
    logic [2:0]  transistor;
    logic [6:0]  d7sp;
    logic        frame_o;

    seg7_scan_mux #(
        .ON_TICKS       (ON_T),
        .BLANK_TICKS    (BLANK_T),
        .CNT_W          (16),
        .SEG_ACTIVE_LOW (1'b0),
        .SEL_ACTIVE_LOW (1'b0)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .en_i           (en_i),
        .digits_i       (digits_i),
        .digits_valid_i (digits_valid_i),
        .lz_blank_i     (lz_blank_i),
        .transistor     (transistor),
        .d7sp           (d7sp),
        .frame_o        (frame_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] sel;
        logic [6:0] seg;
        int         len;
    } slot_t;

    int         checks   = 0;
    int         failures = 0;
    int         edge_n   = 0;
    slot_t      slot_q[$];
    int         frame_q[$];
    logic [6:0] segtab[16];
    bit         mon_off  = 1'b1;

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=event required=none", name);
    endtask

    function automatic logic [6:0] model_seg(input logic [11:0] d, input int s, input bit lz);
        int dig;
        dig = (int'(d) >> (4 * s)) & 15;
        if (lz && s == 2 && d[11:8] == 4'd0) return 7'd0;
        if (lz && s == 1 && d[11:8] == 4'd0 && d[7:4] == 4'd0) return 7'd0;
        return segtab[dig];
    endfunction

    // Monitor: a slot is a run of cycles with a select asserted.
    bit         prev_lit = 1'b0;
    bit         have_cur = 1'b0;
    slot_t      cur;
    int         run_len;
    logic [2:0] cur_sel;
    logic [6:0] cur_seg;

    always @(negedge clk) begin
        if (!mon_off) begin
            if (transistor != 3'd0) begin
                if (!prev_lit) begin
                    if (slot_q.size() == 0) begin
                        fail_now("slot_unexpected");
                        have_cur = 1'b0;
                    end else begin
                        cur = slot_q.pop_front();
                        have_cur = 1'b1;
                        chk("slot_sel", 32'(transistor), 32'(cur.sel));
                        chk("slot_seg", 32'(d7sp), 32'(cur.seg));
                    end
                    run_len = 1;
                    cur_sel = transistor;
                    cur_seg = d7sp;
                end else begin
                    run_len++;
                    chk("slot_stable", 32'({transistor, d7sp}), 32'({cur_sel, cur_seg}));
                end
                prev_lit = 1'b1;
            end else begin
                if (prev_lit && have_cur) chk("slot_len", 32'(run_len), 32'(cur.len));
                chk("dark_seg", 32'(d7sp), 32'd0);
                prev_lit = 1'b0;
                have_cur = 1'b0;
            end
            if (frame_o) begin
                if (frame_q.size() == 0) fail_now("frame_unexpected");
                else chk("frame_edge", 32'(edge_n), 32'(frame_q.pop_front()));
            end
        end
    end

    initial begin : stim
        int          t;
        int          p;
        int          s;
        int          gap;
        int          run_l;
        int          lim;
        bit          sv;
        logic [11:0] val;
        logic [11:0] latest;
        logic [11:0] fdig;
        slot_t       ns;

        segtab = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                   7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111,
                   7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000,
                   7'b1000000};
        rst_n = 1'b0; en_i = 1'b0; digits_i = 12'd0; digits_valid_i = 1'b0; lz_blank_i = 1'b0;
        latest = 12'd0;
        fdig   = 12'd0;
        #12;
        chk("reset_sel", 32'(transistor), 32'd0);
        chk("reset_seg", 32'(d7sp), 32'd0);
        chk("reset_frame", 32'(frame_o), 32'd0);
        @(posedge clk); #1;
        rst_n   = 1'b1;
        mon_off = 1'b0;

        for (int r = 0; r < 14; r++) begin
            gap   = $urandom_range(1, 4);
            run_l = (r == 0) ? 45 : $urandom_range(3, 70);
            for (int c = 0; c < gap + run_l; c++) begin
                @(posedge clk); #1;
                t = edge_n + 1;
                p = c - gap;
                en_i = (c >= gap);
                sv = ($urandom_range(0, 5) == 0) ||
                     (en_i && p > 0 && (p % FRAME_T) == 0 && $urandom_range(0, 1) == 1);
                case ($urandom_range(0, 5))
                    0:       val = 12'h007;
                    1:       val = 12'hA0F;
                    2:       val = 12'h123;
                    3:       val = {($urandom_range(0, 1) == 1) ? 4'd0 : 4'($urandom_range(0, 15)),
                                    ($urandom_range(0, 1) == 1) ? 4'd0 : 4'($urandom_range(0, 15)),
                                    4'($urandom_range(0, 15))};
                    default: val = 12'($urandom);
                endcase
                if (r == 0 && c == 0) begin
                    sv  = 1'b1;
                    val = 12'h123;
                end
                if (r > 0 && $urandom_range(0, 7) == 0) lz_blank_i = ~lz_blank_i;
                digits_valid_i = sv;
                digits_i       = sv ? val : 12'($urandom);

                // Reference: a frame shows the newest digits strobed at or
                // before its start edge; lz is taken when each slot lights.
                if (sv) latest = val;
                if (en_i) begin
                    if ((p % FRAME_T) == 0) begin
                        fdig = latest;
                        if (p > 0) frame_q.push_back(t);
                    end
                    if (((p % FRAME_T) % (ON_T + BLANK_T)) == BLANK_T) begin
                        s      = (p % FRAME_T) / (ON_T + BLANK_T);
                        lim    = run_l - p;
                        ns.sel = 3'(1 << s);
                        ns.seg = model_seg(fdig, s, lz_blank_i);
                        ns.len = (lim < ON_T) ? lim : ON_T;
                        slot_q.push_back(ns);
                    end
                end
            end
        end

        @(posedge clk); #1;
        en_i = 1'b0;
        digits_valid_i = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("slots_left", 32'(slot_q.size()), 32'd0);
        chk("frames_left", 32'(frame_q.size()), 32'd0);

        mon_off = 1'b1;
        en_i = 1'b1;
        for (int k = 0; k < 30 && transistor == 3'd0; k++) @(negedge clk);
        chk("pre_reset_lit", 32'(transistor != 3'd0), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_sel", 32'(transistor), 32'd0);
        chk("async_seg", 32'(d7sp), 32'd0);
        chk("async_frame", 32'(frame_o), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
